// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-granular main memory port between an
// instruction-cache requester (port A) and a data-cache requester (port B).
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests in IDLE are resolved by a round-robin
//                pointer that toggles after every completed read.
//   undefined -> fixed priority, port A wins every tie.
//
// Handshake: a requester raises rd_req and/or wr_req as a level and holds it,
// with addr/wr_line stable, until it sees its one-cycle gnt pulse; the cycle
// carrying gnt is the completion cycle (rd_line is valid in that cycle for a
// read). The memory side follows the same contract with mem_*_req / mem_gnt.
module mem_port_arbiter #(
  parameter  int LINE_ADDR_LEN = 3,
  parameter  int ADDR_LEN      = 9,
  localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  // port A (instruction cache)
  input  logic                a_rd_req,
  input  logic                a_wr_req,
  input  logic [ADDR_LEN-1:0] a_addr,
  input  logic [31:0]         a_wr_line [LINE_SIZE],
  output logic                a_gnt,
  // port B (data cache)
  input  logic                b_rd_req,
  input  logic                b_wr_req,
  input  logic [ADDR_LEN-1:0] b_addr,
  input  logic [31:0]         b_wr_line [LINE_SIZE],
  output logic                b_gnt,
  // read line broadcast to both requesters
  output logic [31:0]         rd_line [LINE_SIZE],
  // main memory side
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [31:0]         mem_wr_line [LINE_SIZE],
  input  logic [31:0]         mem_rd_line [LINE_SIZE],
  input  logic                mem_gnt,
  // current owner: 00 none, 01 A, 10 B
  output logic [1:0]          owner
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWN_A = 2'b01;
  localparam logic [1:0] ST_OWN_B = 2'b10;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic a_any;
  logic b_any;

  assign a_any = a_rd_req | a_wr_req;
  assign b_any = b_rd_req | b_wr_req;

  // State encoding doubles as the owner code.
  assign owner = state_q;

  // Read data is not owner-gated; requesters qualify it with their own gnt.
  assign rd_line = mem_rd_line;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q = 0 -> A wins the next tie, rr_q = 1 -> B wins the next tie.
  logic rr_q;
  logic rr_d;
`endif

  // Next-state: arbitrate in IDLE, hold ownership across write->read pairs.
  always_comb begin
    state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (a_any && b_any) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = rr_q ? ST_OWN_B : ST_OWN_A;
`else
          state_d = ST_OWN_A;
`endif
        end else if (a_any) begin
          state_d = ST_OWN_A;
        end else if (b_any) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!a_any) begin
          // requester withdrew without completion
          state_d = ST_IDLE;
        end else if (mem_gnt && !a_wr_req) begin
          // read completed: release, next tie goes to B
          state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = 1'b1;
`endif
        end
      end
      ST_OWN_B: begin
        if (!b_any) begin
          state_d = ST_IDLE;
        end else if (mem_gnt && !b_wr_req) begin
          state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Forward the owner's request to memory and route mem_gnt back to it only.
  always_comb begin
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      mem_wr_line[i] = '0;
    end
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state_q)
      ST_OWN_A: begin
        mem_addr    = a_addr;
        mem_wr_line = a_wr_line;
        mem_wr_req  = a_wr_req;
        mem_rd_req  = a_rd_req & ~a_wr_req;
        a_gnt       = mem_gnt;
      end
      ST_OWN_B: begin
        mem_addr    = b_addr;
        mem_wr_line = b_wr_line;
        mem_wr_req  = b_wr_req;
        mem_rd_req  = b_rd_req & ~b_wr_req;
        b_gnt       = mem_gnt;
      end
      default: begin
        // IDLE: all memory-side outputs low/zero, stray mem_gnt ignored
      end
    endcase
  end

  // State registers; async reset drops ownership mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. The bench plays both cache
// controllers and the memory: inputs change at the falling edge and outputs
// are sampled 1 time unit later, well away from the rising edge.
module tb_mem_port_arbiter;

  localparam int LS = 8;

  logic              clk;
  logic              rst;
  logic              a_rd_req, a_wr_req, b_rd_req, b_wr_req;
  logic [8:0]        a_addr, b_addr;
  logic [31:0]       a_wr_line [LS];
  logic [31:0]       b_wr_line [LS];
  logic              a_gnt, b_gnt;
  logic [31:0]       rd_line [LS];
  logic              mem_rd_req, mem_wr_req;
  logic [8:0]        mem_addr;
  logic [31:0]       mem_wr_line [LS];
  logic [31:0]       mem_rd_line [LS];
  logic              mem_gnt;
  logic [1:0]        owner;

  logic [31:0]       pat_a [LS];
  logic [31:0]       pat_b [LS];
  logic [31:0]       pat_m [LS];
  logic [31:0]       zero_line [LS];

  int tests_run;
  int tests_failed;

  mem_port_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) dut (
    .clk(clk), .rst(rst),
    .a_rd_req(a_rd_req), .a_wr_req(a_wr_req), .a_addr(a_addr),
    .a_wr_line(a_wr_line), .a_gnt(a_gnt),
    .b_rd_req(b_rd_req), .b_wr_req(b_wr_req), .b_addr(b_addr),
    .b_wr_line(b_wr_line), .b_gnt(b_gnt),
    .rd_line(rd_line),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
    .owner(owner)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit line_eq(input logic [31:0] x [LS], input logic [31:0] y [LS]);
    for (int i = 0; i < LS; i++) if (x[i] !== y[i]) return 1'b0;
    return 1'b1;
  endfunction

  // driver: clear every requester input and the memory gnt
  task automatic drive_idle();
    a_rd_req = 0; a_wr_req = 0; b_rd_req = 0; b_wr_req = 0;
    mem_gnt = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_idle();
    a_addr = 9'h1FF; b_addr = 9'h155;
    a_wr_line = pat_a; b_wr_line = pat_b; mem_rd_line = pat_m;
    a_rd_req = 1; // requests during reset must not leak through
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL reset_owner: got %b want 00", owner); end
    tests_run++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got rd=%b wr=%b want 0 0", mem_rd_req, mem_wr_req); end
    tests_run++; if (mem_addr !== 9'h000) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    tests_run++; if (!line_eq(mem_wr_line, zero_line)) begin tests_failed++; $display("FAIL reset_wr_line: got word0 %h want 0", mem_wr_line[0]); end
    tests_run++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt); end
    @(negedge clk);
    a_rd_req = 0;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_a_read();
    a_addr = 9'h012; a_rd_req = 1; #1;
    tests_run++; if (owner !== 2'b00 || mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL a_rd_arb_cycle: got owner=%b rd=%b want 00 0", owner, mem_rd_req); end
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b01) begin tests_failed++; $display("FAIL a_rd_owner: got %b want 01", owner); end
    tests_run++; if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin tests_failed++; $display("FAIL a_rd_mem_req: got rd=%b wr=%b want 1 0", mem_rd_req, mem_wr_req); end
    tests_run++; if (mem_addr !== 9'h012) begin tests_failed++; $display("FAIL a_rd_addr: got %h want 012", mem_addr); end
    tests_run++; if (a_gnt !== 1'b0) begin tests_failed++; $display("FAIL a_rd_early_gnt: got %b want 0", a_gnt); end
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL a_rd_gnt: got a=%b b=%b want 1 0", a_gnt, b_gnt); end
    tests_run++; if (!line_eq(rd_line, pat_m)) begin tests_failed++; $display("FAIL a_rd_line: got word0 %h want %h", rd_line[0], pat_m[0]); end
    @(negedge clk);
    drive_idle(); #1;
    tests_run++; if (owner !== 2'b00 || a_gnt !== 1'b0) begin tests_failed++; $display("FAIL a_rd_release: got owner=%b gnt=%b want 00 0", owner, a_gnt); end
    @(negedge clk);
  endtask

  task automatic test_b_evict();
    b_addr = 9'h1C0; b_wr_req = 1; #1;
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b10) begin tests_failed++; $display("FAIL b_wr_owner: got %b want 10", owner); end
    tests_run++; if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 9'h1C0) begin tests_failed++; $display("FAIL b_wr_fwd: got wr=%b rd=%b addr=%h want 1 0 1c0", mem_wr_req, mem_rd_req, mem_addr); end
    tests_run++; if (!line_eq(mem_wr_line, pat_b)) begin tests_failed++; $display("FAIL b_wr_line: got word0 %h want %h", mem_wr_line[0], pat_b[0]); end
    mem_gnt = 1; #1;
    tests_run++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin tests_failed++; $display("FAIL b_wr_gnt: got b=%b a=%b want 1 0", b_gnt, a_gnt); end
    @(negedge clk);
    mem_gnt = 0; b_wr_req = 0; b_rd_req = 1; b_addr = 9'h0C0;
    a_rd_req = 1; a_addr = 9'h033; #1;
    tests_run++; if (owner !== 2'b10 || mem_rd_req !== 1'b1 || mem_addr !== 9'h0C0) begin tests_failed++; $display("FAIL b_swapin_keep: got owner=%b rd=%b addr=%h want 10 1 0c0", owner, mem_rd_req, mem_addr); end
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b10 || a_gnt !== 1'b0) begin tests_failed++; $display("FAIL b_a_pending: got owner=%b a_gnt=%b want 10 0", owner, a_gnt); end
    mem_gnt = 1; #1;
    tests_run++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin tests_failed++; $display("FAIL b_rd_gnt: got b=%b a=%b want 1 0", b_gnt, a_gnt); end
    @(negedge clk);
    mem_gnt = 0; b_rd_req = 0; #1;
    tests_run++; if (owner !== 2'b00 || mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL b_idle_gap: got owner=%b rd=%b want 00 0", owner, mem_rd_req); end
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b01 || mem_addr !== 9'h033 || mem_rd_req !== 1'b1) begin tests_failed++; $display("FAIL b_then_a: got owner=%b addr=%h rd=%b want 01 033 1", owner, mem_addr, mem_rd_req); end
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b1) begin tests_failed++; $display("FAIL b_then_a_gnt: got %b want 1", a_gnt); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic [1:0] exp_second;
`ifdef ARB_ROUND_ROBIN_EN
    exp_second = 2'b10;
`else
    exp_second = 2'b01;
`endif
    rst = 1; #1; rst = 0;
    @(negedge clk);
    a_rd_req = 1; a_addr = 9'h0A1; b_rd_req = 1; b_addr = 9'h0B2;
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b01 || mem_addr !== 9'h0A1) begin tests_failed++; $display("FAIL tie1_owner: got owner=%b addr=%h want 01 0a1", owner, mem_addr); end
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL tie1_gnt: got a=%b b=%b want 1 0", a_gnt, b_gnt); end
    @(negedge clk);
    mem_gnt = 0; a_addr = 9'h0A2; // A immediately re-requests: second tie
    @(negedge clk); #1;
    tests_run++; if (owner !== exp_second) begin tests_failed++; $display("FAIL tie2_owner: got %b want %b", owner, exp_second); end
    mem_gnt = 1; #1;
    @(negedge clk);
    mem_gnt = 0;
    if (exp_second == 2'b10) b_rd_req = 0; else a_rd_req = 0;
    @(negedge clk); #1;
    tests_run++; if (owner !== (exp_second ^ 2'b11)) begin tests_failed++; $display("FAIL tie2_other: got %b want %b", owner, exp_second ^ 2'b11); end
    mem_gnt = 1; #1;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_rd_wr_both();
    a_rd_req = 1; a_wr_req = 1; a_addr = 9'h005;
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b01 || mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL both_wr_first: got owner=%b wr=%b rd=%b want 01 1 0", owner, mem_wr_req, mem_rd_req); end
    tests_run++; if (mem_addr !== 9'h005) begin tests_failed++; $display("FAIL both_addr: got %h want 005", mem_addr); end
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b1) begin tests_failed++; $display("FAIL both_wr_gnt: got %b want 1", a_gnt); end
    @(negedge clk);
    mem_gnt = 0; a_wr_req = 0; #1;
    tests_run++; if (owner !== 2'b01 || mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin tests_failed++; $display("FAIL both_rd_after: got owner=%b rd=%b wr=%b want 01 1 0", owner, mem_rd_req, mem_wr_req); end
    mem_gnt = 1; #1;
    @(negedge clk);
    drive_idle(); #1;
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL both_release: got %b want 00", owner); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_rd_req = 1; a_addr = 9'h077;
    @(negedge clk);
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b01 || mem_rd_req !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_owner: got owner=%b rd=%b want 01 1", owner, mem_rd_req); end
    rst = 1; #1;
    tests_run++; if (owner !== 2'b00 || mem_rd_req !== 1'b0 || mem_addr !== 9'h000) begin tests_failed++; $display("FAIL mid_async: got owner=%b rd=%b addr=%h want 00 0 000", owner, mem_rd_req, mem_addr); end
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL mid_no_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt); end
    @(negedge clk);
    drive_idle(); rst = 0;
    @(negedge clk);
    a_rd_req = 1; a_addr = 9'h078;
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b01 || mem_addr !== 9'h078) begin tests_failed++; $display("FAIL mid_fresh: got owner=%b addr=%h want 01 078", owner, mem_addr); end
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b1) begin tests_failed++; $display("FAIL mid_fresh_gnt: got %b want 1", a_gnt); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_idle_gnt();
    mem_gnt = 1; #1;
    tests_run++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL idle_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt); end
    @(negedge clk); #1;
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL idle_gnt_state: got %b want 00", owner); end
    mem_gnt = 0;
    @(negedge clk);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < LS; i++) begin
      pat_a[i] = 32'hA000_0000 + i;
      pat_b[i] = 32'hB000_0100 + i;
      pat_m[i] = 32'h5EED_0000 + (i * 32'h11);
      zero_line[i] = '0;
    end
    test_reset();
    test_a_read();
    test_b_evict();
    test_tie();
    test_rd_wr_both();
    test_reset_mid();
    test_idle_gnt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one line-granular main memory port between two line-fill requesters: port A (instruction cache) and port B (data cache).
- Sits between the two cache controllers and the single main memory instance.
- Grants ownership to one requester at a time and forwards that requester's addr, rd/wr request and write line to memory.
- Routes the memory handshake back to the owner only.
- Keeps ownership across a swap-out (write) followed by its swap-in (read), so dirty evictions are atomic.

Parameters:
- LINE_ADDR_LEN, 3, log2 words per line; LINE_SIZE = 2^LINE_ADDR_LEN.
- ADDR_LEN, 9, line address width (tag + set bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- a_rd_req  in  1  port A line read request; level, held until a_gnt.
- a_wr_req  in  1  port A line write request; level, held until a_gnt.
- a_addr  in  ADDR_LEN  port A line address.
- a_wr_line  in  32 x LINE_SIZE (unpacked)  port A write line.
- a_gnt  out  1  one-cycle completion pulse to A.
- b_rd_req, b_wr_req, b_addr, b_wr_line, b_gnt: same as A, for port B.
- rd_line  out  32 x LINE_SIZE  memory read line, broadcast to both ports; valid in the cycle of the owner's gnt.
- mem_rd_req  out  1  to memory.
- mem_wr_req  out  1  to memory.
- mem_addr  out  ADDR_LEN  to memory.
- mem_wr_line  out  32 x LINE_SIZE  to memory.
- mem_rd_line  in  32 x LINE_SIZE  from memory.
- mem_gnt  in  1  memory completion pulse.
- owner  out  2  00 none, 01 A, 10 B (debug/visibility).

Behaviour:
- States: IDLE, OWN_A, OWN_B, held in a registered state machine.
- Reset: state IDLE, owner 00, rr pointer = A.
- Reset forces mem_rd_req/mem_wr_req 0, a_gnt/b_gnt 0, mem_addr 0, mem_wr_line all-zero.
- Reset mid-transaction abandons the transfer with no gnt; memory is reset by the same rst.
- IDLE:
  - mem requests are 0.
  - If exactly one port has rd_req|wr_req, move to that port's OWN state next edge.
  - If both request, choose by the priority rule (see Optional Feature).
  - Arbitration costs 1 cycle: a request first seen in IDLE at cycle T reaches memory at T+1.
- OWN_x, combinational forwarding:
  - mem_addr = x_addr, mem_wr_line = x_wr_line.
  - mem_wr_req = x_wr_req.
  - mem_rd_req = x_rd_req & ~x_wr_req (write has precedence if both are asserted).
  - x_gnt = mem_gnt; the other port's gnt = 0.
  - rd_line = mem_rd_line at all times.
- OWN_x transitions:
  - mem_gnt with a write completing: stay in OWN_x, so the following swap-in keeps ownership.
  - mem_gnt with a read completing: go to IDLE; rr pointer points to the other port.
  - x drops both requests without gnt (protocol violation / requester reset): go to IDLE next edge, no gnt issued.
- Non-owner requests are held pending; they are never dropped or granted while the other port owns memory.
- Back-to-back: after a read completes, IDLE inserts exactly one idle cycle before the next ownership, giving memory a request-low cycle.
- Starvation bound: with round robin, a waiting port is served after at most one complete transaction (write+read) of the other port.
- mem_gnt received in IDLE is ignored (no gnt to either port).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the port indicated by the rr pointer; the pointer toggles after each read completion.
- Undefined: fixed priority, port A (instruction side) always wins on ties; the rr pointer is not implemented.

Test Plan:
- Single A read addr 0x012 → owner=01 one cycle after request, mem_rd_req=1 with mem_addr=0x012, a_gnt pulses with memory's gnt, rd_line equals memory line, state back to IDLE next cycle, b_gnt stays 0.
- B dirty eviction: wr addr 0x1C0 then rd addr 0x0C0, while A requests read in the cycle after B's write gnt → B keeps ownership (owner=10) for both transfers; A granted only after B's read gnt plus one idle cycle.
- Simultaneous A and B reads from IDLE after reset:
  - With ARB_ROUND_ROBIN_EN: A first, then B.
  - Repeat the tie: B first.
  - Without the macro: A first both times.
- A asserts rd_req and wr_req together (addr 0x005) → mem_wr_req=1, mem_rd_req=0 until the write gnt; then the read proceeds under continued ownership.
- rst asserted 2 cycles into an A read → all outputs zero immediately (asynchronously), owner=00, no a_gnt; after release, a fresh A request is served normally.
- mem_gnt forced high in IDLE with no requests → no a_gnt/b_gnt, state remains IDLE.
